// File: rtl/pow_arb_pkg.sv
// Shared types and widths for the exponentiation-unit arbiter.
package pow_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_e;

   localparam int XW       = 16;
   localparam int NW       = 8;
   localparam int NREQ_MIN = 2;
   localparam int NREQ_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last, wrapping.
module rr_pick
   import pow_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            any,
   output logic [IW-1:0]   win
);

   int d;
   int best;

   // d is the distance from last+1; the smallest distance wins
   always_comb begin
      any  = 1'b0;
      win  = '0;
      best = NREQ;
      d    = 0;
      for (int j = 0; j < NREQ; j++) begin
         d = (j - int'(last) - 1 + NREQ) % NREQ;
         if (req[j] && d < best) begin
            any  = 1'b1;
            win  = IW'(j);
            best = d;
         end
      end
   end

endmodule

// File: rtl/pow_arbiter.sv
// Round-robin arbiter/sequencer sharing one pow unit among NREQ requesters.
// Optional feature macro: POW_TRIVIAL_BYPASS_EN (n=0/1 answered without the unit).
module pow_arbiter
   import pow_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IW = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0][XW-1:0]  req_x,
   input  logic [NREQ-1:0][NW-1:0]  req_n,
   output logic [NREQ-1:0]          ack,
   output logic [NREQ-1:0]          done,
   output logic [XW-1:0]            res,
   output logic                     pow_start,
   output logic [XW-1:0]            pow_x,
   output logic [NW-1:0]            pow_n,
   input  logic                     pow_ready,
   input  logic [XW-1:0]            pow_out
);

   state_e state_q, state_d;
   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [XW-1:0] pow_x_q, pow_x_d;
   logic [NW-1:0] pow_n_q, pow_n_d;
   logic [XW-1:0] res_q, res_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [NREQ-1:0] done_q, done_d;

   logic any;
   logic [IW-1:0] win;
   logic triv;
   logic grant;

   // a requester still shows req during its ack cycle; keep it out of the pick
   rr_pick #(.NREQ(NREQ)) u_pick (
      .req  (req & ~ack_q),
      .last (last_q),
      .any  (any),
      .win  (win)
   );

`ifdef POW_TRIVIAL_BYPASS_EN
   assign triv  = (req_n[win] < NW'(2));
`else
   assign triv  = 1'b0;
`endif
   assign grant = any && (triv || pow_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= IW'(NREQ - 1);
         owner_q <= '0;
         pow_x_q <= '0;
         pow_n_q <= '0;
         res_q   <= '0;
         ack_q   <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         pow_x_q <= pow_x_d;
         pow_n_q <= pow_n_d;
         res_q   <= res_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:      if (grant && !triv) state_d = S_LAUNCH;
         S_LAUNCH:    state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: if (!pow_ready) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (pow_ready) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      last_d  = last_q;
      owner_d = owner_q;
      pow_x_d = pow_x_q;
      pow_n_d = pow_n_q;
      res_d   = res_q;
      ack_d   = '0;
      done_d  = '0;
      if (state_q == S_IDLE && grant) begin
         last_d = win;
         ack_d  = NREQ'(1) << win;
         if (triv) begin
            res_d  = (req_n[win] == '0) ? XW'(1) : req_x[win];
            done_d = NREQ'(1) << win;
         end else begin
            owner_d = win;
            pow_x_d = req_x[win];
            pow_n_d = req_n[win];
         end
      end
      if (state_q == S_WAIT_DONE && pow_ready) begin
         res_d  = pow_out;
         done_d = NREQ'(1) << owner_q;
      end
   end

   assign pow_start = (state_q == S_LAUNCH);
   assign ack       = ack_q;
   assign done      = done_q;
   assign res       = res_q;
   assign pow_x     = pow_x_q;
   assign pow_n     = pow_n_q;

endmodule

// File: tb/tb_pow_arbiter.sv
// Directed bench for pow_arbiter with a behavioural pow unit alongside.
module tb_pow_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0][15:0] req_x = '0;
   logic [3:0][7:0] req_n = '0;
   logic [3:0] ack, done;
   logic [15:0] res;
   logic pow_start;
   logic [15:0] pow_x;
   logic [7:0] pow_n;
   logic pow_ready;
   logic [15:0] pow_out;

   int checks = 0;
   int errors = 0;
   int ack_cnt [4];
   int start_cnt = 0;
   int done_cnt = 0;
   logic [3:0] reassert = '0;
   int order[$];

   int u_cnt;

   always #5 clk = ~clk;

   pow_arbiter #(.NREQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_x     (req_x),
      .req_n     (req_n),
      .ack       (ack),
      .done      (done),
      .res       (res),
      .pow_start (pow_start),
      .pow_x     (pow_x),
      .pow_n     (pow_n),
      .pow_ready (pow_ready),
      .pow_out   (pow_out)
   );

   function automatic logic [15:0] upow(input logic [15:0] b, input logic [7:0] n);
      logic [15:0] r = 16'd1;
      for (int i = 0; i < int'(n); i++) r = r * b;
      return r;
   endfunction

   // pow unit: drops ready the cycle after start, result after a few cycles
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pow_ready <= 1'b1;
         pow_out   <= '0;
         u_cnt     <= 0;
      end else if (pow_ready && pow_start) begin
         pow_ready <= 1'b0;
         pow_out   <= upow(pow_x, pow_n);
         u_cnt     <= 4;
      end else if (!pow_ready) begin
         if (u_cnt == 1) pow_ready <= 1'b1;
         u_cnt <= u_cnt - 1;
      end
   end

   // requester side: drop req after ack, optionally raise it again
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ack[i]) begin
            ack_cnt[i] = ack_cnt[i] + 1;
            req[i] = 1'b0;
         end else if (reassert[i] && !req[i]) begin
            req[i] = 1'b1;
         end
         if (done[i]) order.push_back(i);
      end
      if (pow_start) start_cnt = start_cnt + 1;
      if (done != 0) done_cnt = done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int idx, input logic [15:0] r);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done == 0 && n < 80);
      chk({tag, "_done"}, 32'(done), 32'(4'b1 << idx));
      chk({tag, "_res"}, 32'(res), 32'(r));
   endtask

   task automatic clr_cnt();
      for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
      start_cnt = 0;
      done_cnt = 0;
      order.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      clr_cnt();
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_res", 32'(res), 0);
      chk("rst_start", 32'(pow_start), 0);
      chk("rst_powx", 32'(pow_x), 0);
      chk("rst_pown", 32'(pow_n), 0);
      rst = 1'b0;

      // single job
      @(negedge clk);
      req_x[0] = 16'd3; req_n[0] = 8'd5; req[0] = 1'b1;
      @(negedge clk);
      chk("single_ack", 32'(ack), 32'b0001);
      chk("single_start", 32'(pow_start), 1);
      chk("single_powx", 32'(pow_x), 3);
      wait_done("single", 0, 16'd243);
      repeat (3) @(posedge clk);
      chk("single_nack", 32'(ack_cnt[0]), 1);
      chk("single_nstart", 32'(start_cnt), 1);

      // wrap-around arithmetic
      @(negedge clk);
      req_x[0] = 16'd2; req_n[0] = 8'd16; req[0] = 1'b1;
      wait_done("ovf0", 0, 16'd0);
      @(negedge clk);
      req_x[0] = 16'd3; req_n[0] = 8'd10; req[0] = 1'b1;
      wait_done("ovf1", 0, 16'd59049);

      // contention from reset
      rst = 1'b1;
      req_x[0] = 16'd2;  req_n[0] = 8'd3;
      req_x[1] = 16'd5;  req_n[1] = 8'd2;
      req_x[2] = 16'd7;  req_n[2] = 8'd3;
      req_x[3] = 16'd10; req_n[3] = 8'd4;
      req = 4'b1111;
      repeat (2) @(negedge clk);
      clr_cnt();
      rst = 1'b0;
      wait_done("cont0", 0, 16'd8);
      wait_done("cont1", 1, 16'd25);
      wait_done("cont2", 2, 16'd343);
      wait_done("cont3", 3, 16'd10000);
      repeat (10) @(posedge clk);
      for (int i = 0; i < 4; i++) chk("cont_nack", 32'(ack_cnt[i]), 1);
      chk("cont_ndone", 32'(done_cnt), 4);

      // fairness: 1 keeps coming back, 3 waits
      do_reset();
      clr_cnt();
      req_x[1] = 16'd4; req_n[1] = 8'd2;
      req_x[3] = 16'd6; req_n[3] = 8'd2;
      reassert = 4'b0010;
      req = 4'b1010;
      wait_done("fair0", 1, 16'd16);
      wait_done("fair1", 3, 16'd36);
      reassert = '0;
      wait_done("fair2", 1, 16'd16);
      repeat (3) @(posedge clk);
      chk("fair_order0", 32'(order[0]), 1);
      chk("fair_order1", 32'(order[1]), 3);
      chk("fair_n3", 32'(ack_cnt[3]), 1);

      // reset while waiting for the unit
      do_reset();
      clr_cnt();
      @(negedge clk);
      req_x[0] = 16'd3; req_n[0] = 8'd5; req[0] = 1'b1;
      begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (pow_ready && n < 20);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_ack", 32'(ack), 0);
      chk("mid_done", 32'(done), 0);
      chk("mid_res", 32'(res), 0);
      chk("mid_start", 32'(pow_start), 0);
      chk("mid_powx", 32'(pow_x), 0);
      chk("mid_pown", 32'(pow_n), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      chk("mid_nodone", 32'(done_cnt), 0);
      @(negedge clk);
      req_x[2] = 16'd5; req_n[2] = 8'd3; req[2] = 1'b1;
      wait_done("mid_new", 2, 16'd125);

      // trivial exponents
      clr_cnt();
      @(negedge clk);
      req_x[0] = 16'd9; req_n[0] = 8'd0; req[0] = 1'b1;
      wait_done("triv0", 0, 16'd1);
`ifdef POW_TRIVIAL_BYPASS_EN
      chk("triv0_ack", 32'(ack), 32'b0001);
`endif
      @(negedge clk);
      req_x[1] = 16'd7; req_n[1] = 8'd1; req[1] = 1'b1;
      wait_done("triv1", 1, 16'd7);
`ifdef POW_TRIVIAL_BYPASS_EN
      chk("triv1_ack", 32'(ack), 32'b0010);
`endif
      repeat (3) @(posedge clk);
`ifdef POW_TRIVIAL_BYPASS_EN
      chk("triv_nstart", 32'(start_cnt), 0);
`else
      chk("triv_nstart", 32'(start_cnt), 2);
`endif
      chk("triv_nack", 32'(ack_cnt[0] + ack_cnt[1]), 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
